// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a single-bus CPU datapath.
// Walks fetch (T0..T2) and an opcode-dependent execute sequence (T3..T6),
// driving one-hot datapath strobes. An unknown opcode parks the machine
// in HALT until clear.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [13:0] alu_sel,
    output logic [3:0]  step,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        HALT = 4'd8
    } state_t;

    state_t state_reg;

    // Instruction field extraction; only meaningful from T3 onward, once
    // the datapath has loaded the new instruction into IR.
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_unary;
    logic       is_muldiv;
    logic       is_bad;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign is_unary  = (opcode == 5'd9) || (opcode == 5'd10);
    assign is_muldiv = (opcode == 5'd11) || (opcode == 5'd12);
    assign is_bad    = (opcode > 5'd12);

    // One-hot register selects; field value 0 selects R0 like any other.
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic [15:0] sel_c;
    logic [13:0] alu_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg_sel
            assign sel_a[gi] = (ra == 4'(gi));
            assign sel_b[gi] = (rb == 4'(gi));
            assign sel_c[gi] = (rc == 4'(gi));
        end
        for (gi = 0; gi < 14; gi++) begin : g_alu_sel
            assign alu_onehot[gi] = (opcode == 5'(gi)) && !is_bad;
        end
    endgenerate

    // State register and transitions; clear overrides everything, run is
    // only consulted in IDLE and on the final step of an instruction.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: state_reg <= run ? T0 : IDLE;
                T0:   state_reg <= T1;
                T1:   state_reg <= T2;
                T2:   state_reg <= T3;
                T3:   state_reg <= is_bad ? HALT : T4;
                T4:   state_reg <= is_unary ? (run ? T0 : IDLE) : T5;
                T5:   state_reg <= is_muldiv ? T6 : (run ? T0 : IDLE);
                T6:   state_reg <= run ? T0 : IDLE;
                HALT: state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign step = state_reg;

    // Moore decode of state and IR. Kept combinational because IR is only
    // guaranteed to hold the new instruction once T3 has been entered.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = 16'h0000;
        Rout     = 16'h0000;
        alu_sel  = 14'h0000;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_reg)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_bad) begin
                    illegal = 1'b1;
                end else if (is_unary) begin
                    Rout    = sel_b;
                    alu_sel = alu_onehot;
                    Zin     = 1'b1;
                end else if (is_muldiv) begin
                    Rout = sel_a;
                    Yin  = 1'b1;
                end else begin
                    Rout = sel_b;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                if (is_unary) begin
                    Zlowout = 1'b1;
                    Rin     = sel_a;
                    done    = 1'b1;
                end else begin
                    Rout    = is_muldiv ? sel_b : sel_c;
                    alu_sel = alu_onehot;
                    Zin     = 1'b1;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = sel_a;
                    done = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            HALT: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
